cbus_mem_responder: RTL and testbench



---
 rtl/cbus_mem_responder_pkg.sv | 68 ++++++
 rtl/cbus_resp_ram.sv | 26 ++
 rtl/cbus_mem_responder.sv | 177 +++++++++++++++++
 tb/tb_cbus_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbus_mem_responder_pkg.sv
// cbus request/response types shared by initiators and the memory responder.
// Adds responder FSM states and the latency ceiling.
package cbus_mem_responder_pkg;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [3:0] {
    MLEN1  = 4'd0,
    MLEN2  = 4'd1,
    MLEN3  = 4'd2,
    MLEN4  = 4'd3,
    MLEN5  = 4'd4,
    MLEN6  = 4'd5,
    MLEN7  = 4'd6,
    MLEN8  = 4'd7,
    MLEN9  = 4'd8,
    MLEN10 = 4'd9,
    MLEN11 = 4'd10,
    MLEN12 = 4'd11,
    MLEN13 = 4'd12,
    MLEN14 = 4'd13,
    MLEN15 = 4'd14,
    MLEN16 = 4'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } resp_state_t;

  // byte lanes a write of this size may legally touch
  function automatic logic [3:0] lane_mask(
    input msize_t     size,
    input logic [1:0] lo
  );
    logic [3:0] m;
    unique case (size)
      MSIZE1:  m = 4'b0001 << lo;
      MSIZE2:  m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cbus_resp_ram.sv
// Single-port synchronous RAM, 32-bit words, byte write enables.
// Read-first: a write cycle returns the old word.
module cbus_resp_ram #(
  parameter int MEM_WORDS = 4096
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [3:0]                   we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  // registered read of the old word, byte-masked write
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/cbus_mem_responder.sv
// cbus responder backed by on-chip RAM: latency, then one beat per cycle.
// Define CBUS_RESP_WRAP_EN for critical-word-first wrap bursts.
module cbus_mem_responder
  import cbus_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  cbus_req,
  output cbus_resp_t cbus_resp
);

  localparam int IDX = $clog2(MEM_WORDS);

  resp_state_t    state, state_nx;
  logic [3:0]     cnt, cnt_nx;
  logic [3:0]     beat, beat_nx;
  logic [3:0]     nm1, nm1_nx;
  logic           is_wr, wr_nx;
  logic [IDX-1:0] start, start_nx;
  logic [IDX-1:0] mask, mask_nx;

  logic [IDX-1:0] req_word;
  logic [IDX-1:0] req_mask;
  logic           ready, last;
  logic           ram_en;
  logic [3:0]     ram_we;
  logic [IDX-1:0] ram_addr;
  logic [31:0]    ram_rdata;
  logic           lane_err;
  logic           unused_bits;

  assign req_word = cbus_req.addr[IDX+1:2];

`ifdef CBUS_RESP_WRAP_EN
  // power-of-two bursts wrap inside their N-word block
  always_comb begin
    req_mask = '0;
    unique case (cbus_req.len)
      MLEN2, MLEN4, MLEN8, MLEN16:
        req_mask = IDX'(cbus_req.len);
      default: req_mask = '0;
    endcase
  end
`else
  assign req_mask = '0;
`endif

  // a nonzero mask selects wrap, otherwise linear
  function automatic logic [IDX-1:0] beat_word(
    input logic [IDX-1:0] s,
    input logic [IDX-1:0] m,
    input logic [4:0]     i
  );
    logic [IDX-1:0] lin;
    lin = s + IDX'(i);
    if (|m) return (s & ~m) | (lin & m);
    return lin;
  endfunction

  // lane check is informational; strobe alone decides
  assign lane_err = cbus_req.valid & cbus_req.is_write &
    |(cbus_req.strobe &
      ~lane_mask(cbus_req.size, cbus_req.addr[1:0]));
  assign unused_bits = ^{cbus_req.addr[31:IDX+2],
                         cbus_req.addr[1:0], lane_err};

  // state and burst-context registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      beat  <= '0;
      nm1   <= '0;
      is_wr <= 1'b0;
      start <= '0;
      mask  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      beat  <= beat_nx;
      nm1   <= nm1_nx;
      is_wr <= wr_nx;
      start <= start_nx;
      mask  <= mask_nx;
    end
  end

  // next state, RAM port and handshake outputs
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    beat_nx  = beat;
    nm1_nx   = nm1;
    wr_nx    = is_wr;
    start_nx = start;
    mask_nx  = mask;
    ready    = 1'b0;
    last     = 1'b0;
    ram_en   = 1'b0;
    ram_we   = '0;
    ram_addr = start;
    unique case (state)
      IDLE: begin
        if (cbus_req.valid) begin
          wr_nx    = cbus_req.is_write;
          start_nx = req_word;
          nm1_nx   = cbus_req.len;
          mask_nx  = req_mask;
          cnt_nx   = 4'(LATENCY);
          beat_nx  = '0;
          ram_addr = req_word;
          if (LATENCY == 0) begin
            state_nx = BURST;
            ram_en   = ~cbus_req.is_write;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (!cbus_req.valid) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_nx = BURST;
            ram_en   = ~is_wr;
            ram_addr = start;
          end
        end
      end
      BURST: begin
        if (!cbus_req.valid) begin
          state_nx = IDLE;
        end else begin
          ready  = 1'b1;
          last   = (beat == nm1);
          ram_en = 1'b1;
          if (is_wr) begin
            ram_we   = cbus_req.strobe;
            ram_addr = beat_word(start, mask,
                                 {1'b0, beat});
          end else begin
            ram_addr = beat_word(start, mask,
                                 {1'b0, beat} + 5'd1);
          end
          if (last) state_nx = IDLE;
          else      beat_nx  = beat + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // response bundle; data only on read beats
  always_comb begin
    cbus_resp       = '0;
    cbus_resp.ready = ready;
    cbus_resp.last  = last;
    cbus_resp.data  = (ready && !is_wr) ? ram_rdata : '0;
  end

  cbus_resp_ram #(
    .MEM_WORDS(MEM_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(cbus_req.data),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Bench for cbus_mem_responder: directed table, corner sequences, random.
// Two instances: LATENCY=2 and LATENCY=0.
module tb_cbus_mem_responder;
  import cbus_mem_responder_pkg::*;

  localparam int MW    = 4096;
  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cbus_req_t  req  [2];
  cbus_resp_t resp [2];

  cbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT_A)) dut (
    .clk(clk), .reset(reset),
    .cbus_req(req[0]), .cbus_resp(resp[0]));

  cbus_mem_responder #(.MEM_WORDS(MW), .LATENCY(LAT_B)) dut0 (
    .clk(clk), .reset(reset),
    .cbus_req(req[1]), .cbus_resp(resp[1]));

  logic [31:0] model [2][MW];
  logic [31:0] wbuf [16];
  logic [31:0] rbuf [16];
  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    bit          wr;
    int          addr;
    int          len;
    logic [3:0]  strb;
    msize_t      sz;
    logic [31:0] d [4];
    logic [31:0] e [4];
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(
    input string name, input bit wr, input int addr,
    input int len, input logic [3:0] strb, input msize_t sz,
    input logic [31:0] v0, input logic [31:0] v1,
    input logic [31:0] v2, input logic [31:0] v3);
    vec_t v;
    v.name = name; v.wr = wr; v.addr = addr;
    v.len = len; v.strb = strb; v.sz = sz;
    v.d[0] = v0; v.d[1] = v1; v.d[2] = v2; v.d[3] = v3;
    v.e = v.d;
    return v;
  endfunction

  // which word beat i of a burst touches
  function automatic int word_of(input int start, input int len,
                                 input int i);
    int n;
    n = len + 1;
`ifdef CBUS_RESP_WRAP_EN
    if (n == 2 || n == 4 || n == 8 || n == 16) begin
      int base;
      base = start - (start % n);
      return base + ((start - base + i) % n);
    end
`endif
    return (start + i) % MW;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
    input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit wr, input int addr,
    input int len, input logic [3:0] strb, input msize_t sz);
    req[p].valid    = 1'b1;
    req[p].is_write = wr;
    req[p].size     = sz;
    req[p].addr     = 32'(addr);
    req[p].strobe   = strb;
    req[p].data     = wbuf[0];
    req[p].len      = mlen_t'(4'(len));
  endtask

  // one complete burst, checking beat timing and read data
  task automatic run(input int p, input bit wr, input int addr,
    input int len, input logic [3:0] strb, input msize_t sz);
    int n, lat, c, bt, bad_c, sw;
    int words [16];
    bit bad, er;
    cbus_resp_t r;
    n = len + 1;
    lat = (p == 0) ? LAT_A : LAT_B;
    sw = (addr / 4) % MW;
    for (int i = 0; i < n; i++) words[i] = word_of(sw, len, i);
    drive(p, wr, addr, len, strb, sz);
    c = 0; bt = 0; bad = 0; bad_c = -1;
    while (bt < n && c < lat + n + 8) begin
      @(negedge clk);
      r = resp[p];
      er = (c >= lat + 1) && (c < lat + 1 + n);
      if (r.ready !== er) bad = 1;
      if (r.ready === 1'b1) begin
        if (r.last !== (bt == n - 1)) bad = 1;
        if (wr) model[p][words[bt]] =
          merge(model[p][words[bt]], wbuf[bt], strb);
        else rbuf[bt] = r.data;
        bt++;
      end else if (r.last !== 1'b0) begin
        bad = 1;
      end
      if (bad && bad_c < 0) bad_c = c;
      @(posedge clk); #1;
      c++;
      if (bt < n) req[p].data = wbuf[bt];
    end
    req[p] = '0;
    checks++;
    if (bad || bt != n) begin
      errors++;
      $display("FAIL timing p%0d addr %h len %0d: bad cycle %0d, %0d of %0d beats",
               p, addr, len, bad_c, bt, n);
    end
    if (!wr)
      for (int i = 0; i < n; i++)
        chk($sformatf("rd p%0d w%0d", p, words[i]),
            rbuf[i], model[p][words[i]]);
  endtask

  initial begin
    int c, bt, a, l;
    bit w;
    req[0] = '0;
    req[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset resp0", 32'(resp[0]), 32'h0);
    chk("reset resp1", 32'(resp[1]), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle resp0", 32'(resp[0]), 32'h0);
    @(posedge clk); #1;

    for (int b = 0; b < 9; b++) begin
      int base;
      base = (b < 8) ? b * 16 : MW - 16;
      for (int i = 0; i < 16; i++) wbuf[i] = 32'h1000_0000 + 32'(base + i);
      run(0, 1, base * 4, 15, 4'hF, MSIZE4);
    end

    tbl[0] = mk("wrap_order", 0, 32'h0C, 3, 4'h0, MSIZE4, 0, 0, 0, 0);
`ifdef CBUS_RESP_WRAP_EN
    tbl[0].e = '{32'h1000_0003, 32'h1000_0000,
                 32'h1000_0001, 32'h1000_0002};
`else
    tbl[0].e = '{32'h1000_0003, 32'h1000_0004,
                 32'h1000_0005, 32'h1000_0006};
`endif
    tbl[1] = mk("wr_40", 1, 32'h40, 1, 4'hF, MSIZE4,
                32'hDEADBEEF, 32'h0BADF00D, 0, 0);
    tbl[2] = mk("rd_40", 0, 32'h40, 1, 4'h0, MSIZE4,
                32'hDEADBEEF, 32'h0BADF00D, 0, 0);
    tbl[3] = mk("wr_80", 1, 32'h80, 3, 4'hF, MSIZE4, 1, 2, 3, 4);
    tbl[4] = mk("rd_80", 0, 32'h80, 3, 4'h0, MSIZE4, 1, 2, 3, 4);
    tbl[5] = mk("wr_strb", 1, 32'h80, 0, 4'b0011, MSIZE2,
                32'hAABBCCDD, 0, 0, 0);
    tbl[6] = mk("rd_strb", 0, 32'h80, 0, 4'h0, MSIZE4,
                32'h0000CCDD, 0, 0, 0);
    tbl[7] = mk("wr_top", 1, (MW - 1) * 4, 1, 4'hF, MSIZE4,
                32'hCAFE0001, 32'hCAFE0002, 0, 0);
    tbl[8] = mk("rd_top", 0, (MW - 1) * 4, 1, 4'h0, MSIZE4,
                32'hCAFE0001, 32'hCAFE0002, 0, 0);
`ifdef CBUS_RESP_WRAP_EN
    tbl[9] = mk("rd_w0", 0, 0, 0, 4'h0, MSIZE4, 32'h1000_0000, 0, 0, 0);
`else
    tbl[9] = mk("rd_w0", 0, 0, 0, 4'h0, MSIZE4, 32'hCAFE0002, 0, 0, 0);
`endif

    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 16; i++) wbuf[i] = (i < 4) ? tbl[t].d[i] : 0;
      run(0, tbl[t].wr, tbl[t].addr, tbl[t].len, tbl[t].strb, tbl[t].sz);
      if (!tbl[t].wr)
        for (int i = 0; i <= tbl[t].len; i++)
          chk($sformatf("%s[%0d]", tbl[t].name, i), rbuf[i], tbl[t].e[i]);
    end

    wbuf[0] = 32'h12345678;
    run(1, 1, 32'h14, 0, 4'hF, MSIZE4);
    run(1, 0, 32'h14, 0, 4'h0, MSIZE4);
    chk("lat0 raw", rbuf[0], 32'h12345678);
    wbuf[0] = 32'h9ABCDEF0;
    run(1, 1, 32'h18, 0, 4'hF, MSIZE4);
    run(1, 0, 32'h14, 0, 4'h0, MSIZE4);
    run(1, 0, 32'h18, 0, 4'h0, MSIZE4);
    chk("lat0 b2b", rbuf[0], 32'h9ABCDEF0);

    wbuf[0] = 0;
    drive(0, 0, 0, 7, 4'h0, MSIZE4);
    c = 0; bt = 0;
    while (bt < 2 && c < 20) begin
      @(negedge clk);
      if (resp[0].ready === 1'b1) bt++;
      @(posedge clk); #1;
      c++;
    end
    chk("rst beats seen", 32'(bt), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req[0] = '0;
    @(negedge clk);
    chk("rst resp", 32'(resp[0]), 32'h0);
    @(posedge clk); #1;
    run(0, 0, 0, 7, 4'h0, MSIZE4);

    for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + 32'(i);
    drive(0, 1, 32'hC0, 3, 4'hF, MSIZE4);
    c = 0; bt = 0;
    while (bt < 2 && c < 20) begin
      @(negedge clk);
      if (resp[0].ready === 1'b1) begin
        model[0][48 + bt] = wbuf[bt];
        bt++;
      end
      @(posedge clk); #1;
      c++;
      req[0].data = wbuf[bt];
    end
    chk("abort beats seen", 32'(bt), 32'd2);
    req[0].valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort resp", 32'(resp[0]), 32'h0);
    @(posedge clk); #1;
    run(0, 0, 32'hC0, 3, 4'h0, MSIZE4);
    chk("abort kept", rbuf[2], 32'h1000_0032);

    for (int k = 0; k < 60; k++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = MW - 16 + int'($urandom_range(0, 15));
      else a = int'($urandom_range(0, 99));
      l = int'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
      run(0, w, a * 4 + int'($urandom_range(0, 3)), l,
          4'($urandom_range(0, 15)), MSIZE4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
